// File: rtl/cordic_req_arbiter.sv
// Round-robin front end sharing one iterative CORDIC core.
// A watchdog aborts hung core transactions and flags them.
module cordic_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      req_angle,
  output logic [NREQ-1:0]         ack,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [W-1:0]            res_x,
  output logic [W-1:0]            res_y,
  output logic                    res_err,
  output logic                    busy,
  output logic                    core_start,
  output logic [AW-1:0]           core_angle,
  input  logic                    core_done,
  input  logic [W-1:0]            core_x,
  input  logic [W-1:0]            core_y
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RET   = 2'd3
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [TW-1:0]   timer_q;
  logic [NREQ-1:0] ack_q;
  logic            res_valid_q;
  logic [IDW-1:0]  res_id_q;
  logic [W-1:0]    res_x_q;
  logic [W-1:0]    res_y_q;
  logic            res_err_q;
  logic            busy_q;
  logic            core_start_q;
  logic [AW-1:0]   core_angle_q;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic [AW-1:0]   gnt_angle;
  logic [NREQ-1:0] id_onehot;
  logic [IDW-1:0]  ptr_d;
  logic            timeout_hit;

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req[(int'(ptr_q) + i) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
    gnt_angle   = req_angle[int'(gnt_id)*AW +: AW];
    id_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
    ptr_d       = IDW'((int'(id_q) + 1) % NREQ);
    timeout_hit = (timer_q == TW'(TIMEOUT - 1));
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      timer_q      <= '0;
      ack_q        <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      res_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_angle_q <= '0;
    end else begin
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      ack_q        <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            id_q         <= gnt_id;
            core_angle_q <= gnt_angle;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (core_done || timeout_hit) begin
            res_x_q     <= core_done ? core_x : '0;
            res_y_q     <= core_done ? core_y : '0;
            res_err_q   <= ~core_done;
            res_valid_q <= 1'b1;
            ack_q       <= id_onehot;
            res_id_q    <= id_q;
            state_q     <= S_RET;
          end
        end
        S_RET: begin
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_x      = res_x_q;
  assign res_y      = res_y_q;
  assign res_err    = res_err_q;
  assign busy       = busy_q;
  assign core_start = core_start_q;
  assign core_angle = core_angle_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter.
// Core behaviour is modelled by driving core_done/core_x/core_y.
module tb_cordic_req_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int AW      = 32;
  localparam int TIMEOUT = 64;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_angle;
  logic [NREQ-1:0]    ack;
  logic               res_valid;
  logic [1:0]         res_id;
  logic [W-1:0]       res_x;
  logic [W-1:0]       res_y;
  logic               res_err;
  logic               busy;
  logic               core_start;
  logic [AW-1:0]      core_angle;
  logic               core_done;
  logic [W-1:0]       core_x;
  logic [W-1:0]       core_y;

  int checks = 0;
  int errors = 0;

  cordic_req_arbiter #(
    .NREQ(NREQ), .W(W), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_angle(req_angle),
    .ack(ack), .res_valid(res_valid), .res_id(res_id),
    .res_x(res_x), .res_y(res_y), .res_err(res_err),
    .busy(busy), .core_start(core_start),
    .core_angle(core_angle), .core_done(core_done),
    .core_x(core_x), .core_y(core_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ang(input int id, input logic [31:0] a);
    req_angle[id*AW +: AW] = a;
  endtask

  // Entered in an IDLE cycle with req already set; the next edge is the
  // grant edge (edge 0). Cycle c lies between edge c-1 and edge c.
  // k = edge where core_done is sampled; k = 0 means no done (timeout).
  task automatic run_txn(input string tag, input int id,
                         input logic [31:0] ang, input int k,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic err);
    int c;
    int expc;
    logic [15:0] ex;
    logic [15:0] ey;
    tick();
    c = 1;
    chk({tag, ".start"}, core_start, 1'b1);
    chk({tag, ".angle"}, core_angle, ang);
    chk({tag, ".busy"}, busy, 1'b1);
    while (res_valid !== 1'b1 && c < 120) begin
      core_done = (c == k);
      core_x    = (c == k) ? x : 16'hDEAD;
      core_y    = (c == k) ? y : 16'hBEEF;
      if (c == 2) begin
        chk({tag, ".start_pulse"}, core_start, 1'b0);
        set_ang(id, ~ang);
      end
      tick();
      c++;
    end
    core_done = 1'b0;
    expc = (k > 0) ? k + 1 : TIMEOUT + 2;
    ex   = err ? 16'h0 : x;
    ey   = err ? 16'h0 : y;
    chk({tag, ".lat"}, c, expc);
    chk({tag, ".ack"}, ack, 4'b0001 << id);
    chk({tag, ".id"}, res_id, id);
    chk({tag, ".x"}, res_x, ex);
    chk({tag, ".y"}, res_y, ey);
    chk({tag, ".err"}, res_err, err);
    chk({tag, ".hold_angle"}, core_angle, ang);
    set_ang(id, ang);
    req[id] = 1'b0;
    tick();
    chk({tag, ".vld_pulse"}, res_valid, 1'b0);
    chk({tag, ".ack_pulse"}, ack, 4'b0000);
    chk({tag, ".idle"}, busy, 1'b0);
    chk({tag, ".x_hold"}, res_x, ex);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_angle = '0;
    core_done = 1'b0;
    core_x    = '0;
    core_y    = '0;
    tick();
    tick();
    chk("rst.busy", busy, 1'b0);
    chk("rst.valid", res_valid, 1'b0);
    chk("rst.ack", ack, 4'b0000);
    chk("rst.start", core_start, 1'b0);
    chk("rst.angle", core_angle, 32'h0);
    chk("rst.xy", {res_x, res_y}, 32'h0);
    chk("rst.id_err", {res_id, res_err}, 3'b000);
    rst_n = 1'b1;
    tick();

    // Single request, 1 degree
    set_ang(0, 32'h00B60B60);
    req = 4'b0001;
    run_txn("single", 0, 32'h00B60B60, 35, 16'd4096, 16'd71, 1'b0);

    // Simultaneous requests from reset
    do_reset();
    set_ang(1, 32'h11111111);
    set_ang(3, 32'h33333333);
    req = 4'b1010;
    run_txn("sim1", 1, 32'h11111111, 5, 16'h0101, 16'h0202, 1'b0);
    run_txn("sim3", 3, 32'h33333333, 9, 16'h0303, 16'h0404, 1'b0);

    // Fairness with all requests re-asserted after each ack
    for (int i = 0; i < NREQ; i++) set_ang(i, 32'hA0000000 + i);
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      run_txn($sformatf("fair%0d", t), t % 4, 32'hA0000000 + (t % 4),
              3 + t, 16'(100 + t), 16'(200 + t), 1'b0);
      req[t % 4] = 1'b1;
    end
    req = 4'b0000;

    // Timeout, then a normal request
    set_ang(2, 32'h40000000);
    req = 4'b0100;
    run_txn("tmo", 2, 32'h40000000, 0, 16'h0, 16'h0, 1'b1);
    set_ang(0, 32'h12345678);
    req = 4'b0001;
    run_txn("after_tmo", 0, 32'h12345678, 6, 16'h0ABC, 16'h0DEF, 1'b0);

    // core_done on the timeout edge: done wins
    set_ang(3, 32'h80000000);
    req = 4'b1000;
    run_txn("bound", 3, 32'h80000000, TIMEOUT + 1, 16'hFFFB,
            16'd1234, 1'b0);

    // Reset during WAIT followed by a stray done in IDLE
    set_ang(1, 32'h55555555);
    req = 4'b0010;
    tick();
    chk("mid.start", core_start, 1'b1);
    tick();
    tick();
    tick();
    chk("mid.busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid.async_busy", busy, 1'b0);
    tick();
    tick();
    req   = 4'b0000;
    rst_n = 1'b1;
    tick();
    core_done = 1'b1;
    core_x    = 16'd777;
    core_y    = 16'd888;
    tick();
    core_done = 1'b0;
    chk("stray.valid", res_valid, 1'b0);
    chk("stray.ack", ack, 4'b0000);
    chk("stray.busy", busy, 1'b0);
    tick();
    chk("stray.xy", {res_x, res_y}, 32'h0);
    chk("stray.angle", core_angle, 32'h0);
    set_ang(2, 32'h2AAAAAAA);
    req = 4'b0100;
    run_txn("post_rst", 2, 32'h2AAAAAAA, 4, 16'h1111, 16'h2222, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
